// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Pulls DATA_LEN-bit words from a FIFO with registered read data and sends
//   each word as DATA_LEN/8 back-to-back 8N1 frames, byte 0 first, LSB first.
//
// Ports
//   rd_clk      in   single clock, rising edge
//   reset       in   synchronous, active-high
//   fifo_empty  in   upstream FIFO holds no words
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  one-cycle read request per word
//   tx          out  registered serial line, idle high
//   busy        out  high whenever the FSM is not idle
//   word_done   out  pulse in the final cycle of the last stop bit of a word
//
// State     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | line idle, waiting for a word in the FIFO
// S_FETCH   | fifo_rd_en asserted for one cycle
// S_CAPTURE | FIFO read data arrives; latched into the shift register
// S_START   | start bit (tx=0) of the current byte
// S_DATA    | eight data bits, LSB first
// S_STOP    | stop bit (tx=1); then next byte, next word, or idle

module uart_word_tx #(
  parameter int DATA_LEN     = 16,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic                rd_clk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [DATA_LEN-1:0] fifo_data,
  output logic                fifo_rd_en,
  output logic                tx,
  output logic                busy,
  output logic                word_done
);

  localparam int NUM_BYTES = DATA_LEN / 8;
  localparam int BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  generate
    if ((DATA_LEN % 8) != 0 || DATA_LEN < 8) begin : g_bad_data_len
      $error("uart_word_tx: DATA_LEN must be a non-zero multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [2:0]            r_bit_idx;
  logic [BYTE_W-1:0]     r_byte_idx;
  logic [DATA_LEN-1:0]   r_shift;
  logic                  r_tx;

  state_t                w_state_next;
  logic [BAUD_W-1:0]     w_baud_next;
  logic [2:0]            w_bit_next;
  logic [BYTE_W-1:0]     w_byte_next;
  logic [DATA_LEN-1:0]   w_shift_next;
  logic                  w_tx_next;
  logic                  w_bit_end;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_byte_idx <= w_byte_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_idx;
    w_byte_next  = r_byte_idx;
    w_shift_next = r_shift;
    w_bit_end    = (r_baud == BAUD_LAST);
    fifo_rd_en   = 1'b0;
    word_done    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_state_next = S_FETCH;
        end
      end

      // Guarded so a FIFO flushed between IDLE and FETCH never sees a read.
      S_FETCH: begin
        if (fifo_empty) begin
          w_state_next = S_IDLE;
        end else begin
          fifo_rd_en   = 1'b1;
          w_state_next = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        w_shift_next = fifo_data;
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_byte_next  = '0;
        w_state_next = S_START;
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

      // The shift register advances one bit per data bit across the whole
      // word, so bit 0 is always the next bit to put on the line.
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_bit_next   = '0;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_byte_idx == BYTE_LAST) begin
            word_done    = 1'b1;
            w_byte_next  = '0;
            w_state_next = fifo_empty ? S_IDLE : S_FETCH;
          end else begin
            w_byte_next  = r_byte_idx + BYTE_W'(1);
            w_state_next = S_START;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // tx is registered, so its next value follows the next state.
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx   = r_tx;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------
  // Instance at default parameters: directed, literal expectations
  // ---------------------------------------------------------------------
  logic        d_reset, d_empty;
  logic [15:0] d_data;
  logic        d_rd_en, d_tx, d_busy, d_done;

  uart_word_tx dut_def (
    .rd_clk    (clk),
    .reset     (d_reset),
    .fifo_empty(d_empty),
    .fifo_data (d_data),
    .fifo_rd_en(d_rd_en),
    .tx        (d_tx),
    .busy      (d_busy),
    .word_done (d_done)
  );

  // ---------------------------------------------------------------------
  // Fast instance (4 clocks per bit): random stimulus vs behavioural model
  // ---------------------------------------------------------------------
  localparam int CPB      = 4;
  localparam int NB       = 2;
  localparam int WORD_CYC = 2 + NB * 10 * CPB;

  logic        f_reset, f_empty;
  logic [15:0] f_data;
  logic        f_rd_en, f_tx, f_busy, f_done;

  uart_word_tx #(.DATA_LEN(16), .CLKS_PER_BIT(CPB)) dut_fast (
    .rd_clk    (clk),
    .reset     (f_reset),
    .fifo_empty(f_empty),
    .fifo_data (f_data),
    .fifo_rd_en(f_rd_en),
    .tx        (f_tx),
    .busy      (f_busy),
    .word_done (f_done)
  );

  logic [15:0] f_q[$];
  logic [15:0] m_q[$];
  bit          m_act;
  int          m_t;
  logic [15:0] m_word;
  int          f_npulse = 0;
  int          f_ndone  = 0;
  int          f_rd_times[$];

  bit def_done  = 0;
  bit fast_done = 0;

  // Expected outputs {rd_en, busy, tx, word_done} for the current cycle,
  // from the word's timeline: offset 0 is the read, 1 the capture, then
  // NB frames of 10 bits, CPB cycles each.
  function automatic logic [3:0] model_outs();
    int   u, bp, fr, b;
    logic e_rd, e_busy, e_tx, e_done;
    e_rd = 1'b0; e_busy = 1'b0; e_tx = 1'b1; e_done = 1'b0;
    if (m_act) begin
      e_busy = 1'b1;
      e_rd   = (m_t == 0) && !f_empty;
      if (m_t >= 2) begin
        u  = m_t - 2;
        bp = u / CPB;
        fr = bp / 10;
        b  = bp % 10;
        if (b == 0)      e_tx = 1'b0;
        else if (b == 9) e_tx = 1'b1;
        else             e_tx = m_word[fr * 8 + b - 1];
        e_done = (u == NB * 10 * CPB - 1);
      end
    end
    return {e_rd, e_busy, e_tx, e_done};
  endfunction

  task automatic model_step(input logic rst_e, input logic emp_e);
    if (m_act && m_t == 0 && !emp_e && m_q.size() > 0) m_word = m_q.pop_front();
    if (rst_e)                          m_act = 0;
    else if (!m_act) begin
      if (!emp_e) begin m_act = 1; m_t = 0; end
    end
    else if (m_t == 0 && emp_e)         m_act = 0;
    else if (m_t == WORD_CYC - 1) begin
      if (!emp_e) m_t = 0;
      else        m_act = 0;
    end
    else                                m_t++;
  endtask

  task automatic push(input logic [15:0] w);
    f_q.push_back(w);
    m_q.push_back(w);
  endtask

  // One clock of the fast instance: compare at the falling edge, then apply
  // the rising edge to the bench FIFO and the model.
  task automatic cycle_f();
    logic [3:0] e, a;
    logic       rd_s, rst_e, emp_e, popped;
    f_empty = (f_q.size() == 0);
    @(negedge clk);
    e = model_outs();
    a = {f_rd_en, f_busy, f_tx, f_done};
    check("fast_outs", a, e);
    rd_s = f_rd_en;
    if (rd_s) begin f_npulse++; f_rd_times.push_back(cyc); end
    if (f_done) f_ndone++;
    @(posedge clk); #1;
    rst_e  = f_reset;
    emp_e  = f_empty;
    popped = 1'b0;
    if (rd_s && f_q.size() > 0) begin f_data = f_q.pop_front(); popped = 1'b1; end
    if (!popped) f_data = 16'($urandom);
    model_step(rst_e, emp_e);
  endtask

  // ---------------------------------------------------------------------
  // Default-parameter directed test
  // ---------------------------------------------------------------------
  initial begin : p_def
    logic [0:19] exp_seq;
    logic [4:0]  bi;
    int bad, n_rd, n_done, t_rd, t_fall, t_done, line_bad;
    logic prev_tx, busy_after, rd_seen;
    exp_seq = 20'b0010110101_0101001011;
    d_reset = 1'b1; d_empty = 1'b1; d_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("def_reset_tx", d_tx, 1);
    check("def_reset_busy", d_busy, 0);
    @(posedge clk); #1 d_reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (d_tx !== 1'b1 || d_rd_en !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0) bad++;
    end
    check("def_idle_1000_bad_cycles", bad, 0);

    @(posedge clk); #1 d_empty = 1'b0;
    n_rd = 0; n_done = 0; t_rd = -1; t_fall = -1; t_done = -1; line_bad = 0;
    prev_tx = 1'b1; busy_after = 1'b1;
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      rd_seen = d_rd_en;
      if (rd_seen) begin n_rd++; if (t_rd < 0) t_rd = cyc; end
      if (t_rd >= 0 && t_fall < 0 && prev_tx && !d_tx) t_fall = cyc;
      if (t_rd >= 0 && cyc >= t_rd + 2 && cyc <= t_rd + 8681) begin
        bi = 5'((cyc - t_rd - 2) / 434);
        if (d_tx !== exp_seq[bi]) line_bad++;
      end
      if (d_done) begin n_done++; t_done = cyc; end
      if (t_rd >= 0 && cyc == t_rd + 8682) busy_after = d_busy;
      prev_tx = d_tx;
      @(posedge clk); #1;
      if (rd_seen) begin d_empty = 1'b1; d_data = 16'hA55A; end
      else         d_data = 16'($urandom);
    end
    check("def_rd_pulses", n_rd, 1);
    check("def_tx_fall_offset", t_fall - t_rd, 2);
    check("def_line_bad_cycles", line_bad, 0);
    check("def_word_done_pulses", n_done, 1);
    check("def_word_done_offset", t_done - t_rd, 8681);
    check("def_busy_after_word", busy_after, 0);
    def_done = 1;
  end

  // ---------------------------------------------------------------------
  // Fast instance scenarios
  // ---------------------------------------------------------------------
  initial begin : p_fast
    int p0, d0, r0, rc;
    bit found;
    f_reset = 1'b1; f_empty = 1'b1; f_data = '0;
    m_act = 0; m_t = 0; m_word = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle_f();
    f_reset = 1'b0;
    repeat (5) cycle_f();

    // Three queued words, back to back
    p0 = f_npulse; r0 = f_rd_times.size();
    for (int i = 0; i < 3; i++) push(16'($urandom));
    repeat (3 * WORD_CYC + 30) cycle_f();
    check("A_pulses", f_npulse - p0, 3);
    if (f_rd_times.size() >= r0 + 3) begin
      check("A_gap1", f_rd_times[r0 + 1] - f_rd_times[r0], 82);
      check("A_gap2", f_rd_times[r0 + 2] - f_rd_times[r0 + 1], 82);
    end else begin
      check("A_gap_pulses_seen", f_rd_times.size() - r0, 3);
    end

    // FIFO drained while a word is in flight
    p0 = f_npulse; d0 = f_ndone;
    push(16'($urandom)); push(16'($urandom));
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_act && m_t == 30) begin found = 1; break; end
      cycle_f();
    end
    check("B_reached_mid_word", found, 1);
    f_q.delete(); m_q.delete();
    repeat (150) cycle_f();
    check("B_pulses", f_npulse - p0, 1);
    check("B_done", f_ndone - d0, 1);
    check("B_busy_idle", f_busy, 0);

    // Reset during data bit 3 of byte 0, second word pending
    p0 = f_npulse; d0 = f_ndone;
    push(16'($urandom)); push(16'($urandom));
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_act && m_t == 19) begin found = 1; break; end
      cycle_f();
    end
    check("C_reached_bit3", found, 1);
    r0 = f_rd_times.size();
    rc = cyc;
    f_reset = 1'b1;
    cycle_f();
    f_reset = 1'b0;
    repeat (2 * WORD_CYC) cycle_f();
    if (f_rd_times.size() > r0) check("C_rd_after_reset", f_rd_times[r0] - rc, 2);
    else                        check("C_rd_after_reset_seen", 0, 1);
    check("C_pulses", f_npulse - p0, 2);
    check("C_done", f_ndone - d0, 1);

    // Reset on the read cycle: popped word is lost
    p0 = f_npulse; d0 = f_ndone;
    push(16'($urandom)); push(16'($urandom));
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (m_act && m_t == 0) begin found = 1; break; end
      cycle_f();
    end
    check("D_reached_fetch", found, 1);
    f_reset = 1'b1;
    cycle_f();
    f_reset = 1'b0;
    repeat (2 * WORD_CYC) cycle_f();
    check("D_pulses", f_npulse - p0, 2);
    check("D_done", f_ndone - d0, 1);
    check("D_fifo_left", f_q.size(), 0);

    // Random traffic, resets and flushes
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(29, 0) == 0 && f_q.size() < 4) push(16'($urandom));
      if ($urandom_range(299, 0) == 0) begin f_q.delete(); m_q.delete(); end
      f_reset = ($urandom_range(399, 0) == 0);
      cycle_f();
    end
    f_reset = 1'b0;
    repeat (3 * WORD_CYC) cycle_f();
    check("E_fifo_level_vs_model", f_q.size(), m_q.size());
    fast_done = 1;
  end

  initial begin : p_end
    wait (def_done && fast_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : p_watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
